gb_cpu_fetch_unit: RTL and testbench

Instruction-byte fetch responder for the GameBoy CPU core. It serves the decoder's byte requests: READ_OPCODE, READ_CB_OPCODE, READ_R8, READ_R16_BYTE0 and READ_R16_BYTE1. Each request triggers one memory read at the program counter, returns the byte tagged with the request kind and address, and post-increments PC. It sits between the decoder and the memory bus interface. It also owns PC loading for jumps, calls, RST and returns.

---
 rtl/gb_cpu_fetch_unit.sv | 90 +++++++++
 tb/tb_gb_cpu_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_fetch_unit.sv
// Instruction-byte fetch responder: serves one decoder byte request at a time from
// memory at PC, tags the byte with the request kind and address, and owns PC loads.
module gb_cpu_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_kind,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [2:0]  rsp_kind,
    output logic [15:0] rsp_pc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    output logic [15:0] pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rdata_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [15:0] addr_q;

    // A pending PC load blocks acceptance so the request never reads a stale PC.
    assign req_ready = rst_n && (state == ST_IDLE) && !pc_load;
    assign mem_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            addr_q    <= 16'h0000;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_kind  <= 3'b000;
            rsp_pc    <= 16'h0000;
        end else begin
            if (pc_load) begin
                pc <= pc_load_value;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        rsp_kind <= req_kind;
                        addr_q   <= pc;
                        mem_rd   <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // The bus read cannot be cancelled: without data in hand, wait it out in DRAIN.
                    if (pc_load) begin
                        mem_rd <= 1'b0;
                        state  <= mem_rdata_valid ? ST_IDLE : ST_DRAIN;
                    end else if (mem_rdata_valid) begin
                        mem_rd    <= 1'b0;
                        rsp_data  <= mem_rdata;
                        rsp_pc    <= addr_q;
                        rsp_valid <= 1'b1;
                        pc        <= pc + 16'd1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (pc_load || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rdata_valid && !pc_load) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Bench for gb_cpu_fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_gb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_kind = 3'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_kind;
    logic [15:0] rsp_pc;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
    logic [15:0] pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_rdata_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int nvalid = 0;

    gb_cpu_fetch_unit #(.RESET_PC(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_kind(req_kind), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_kind(rsp_kind), .rsp_pc(rsp_pc),
        .pc_load(pc_load), .pc_load_value(pc_load_value), .pc(pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory: one read at a time, answers lat cycles after it first sees mem_rd.
    int         lat = 0;
    bit         stray_en = 0;
    bit         mbusy = 0;
    int         mcnt = 0;
    logic [15:0] maddr = 16'h0000;
    logic [7:0] dq[$];

    always @(posedge clk) begin
        #1;
        mem_rdata_valid = 1'b0;
        if (!mbusy && mem_rd) begin
            mbusy = 1;
            mcnt  = lat;
            maddr = mem_addr;
        end
        if (mbusy) begin
            if (mcnt == 0) begin
                mem_rdata_valid = 1'b1;
                if (dq.size() > 0) mem_rdata = dq.pop_front();
                else               mem_rdata = mem_byte(maddr);
                mbusy = 0;
            end else begin
                mcnt--;
            end
        end else if (stray_en && !mem_rd && $urandom_range(7) == 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 8'($urandom);
        end
    end

    // Transaction-level model: a read in progress, an abandoned read, or a held response.
    bit          m_init = 0;
    bit          m_reading, m_orphan, m_have, m_acc;
    logic [15:0] m_pc, m_maddr, m_rpc;
    logic [2:0]  m_kind;
    logic [7:0]  m_data;

    function automatic logic m_ready();
        return rst_n && !m_reading && !m_orphan && !m_have && !pc_load;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1; m_pc = 16'h0100;
            m_reading = 0; m_orphan = 0; m_have = 0;
            m_maddr = 16'h0000; m_rpc = 16'h0000; m_kind = 3'd0; m_data = 8'h00;
        end else if (m_init) begin
            m_acc = req_valid && m_ready();
            if (pc_load) m_pc = pc_load_value;
            if (m_reading) begin
                if (pc_load) begin
                    m_reading = 0;
                    m_orphan  = !mem_rdata_valid;
                end else if (mem_rdata_valid) begin
                    m_reading = 0;
                    m_have = 1; m_data = mem_rdata; m_rpc = m_maddr; m_pc = m_pc + 16'd1;
                end
            end else if (m_orphan) begin
                if (mem_rdata_valid && !pc_load) m_orphan = 0;
            end else if (m_have) begin
                if (pc_load || rsp_ready) m_have = 0;
            end else if (m_acc) begin
                m_reading = 1; m_maddr = m_pc; m_kind = req_kind;
            end
        end
    end

    logic [15:0] lg_pc[$];
    logic [2:0]  lg_kind[$];
    logic [7:0]  lg_data[$];

    always @(negedge clk) begin
        if (m_init) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            chk("mem_rd",    32'(mem_rd),    32'(m_reading));
            chk("mem_addr",  32'(mem_addr),  32'(m_maddr));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_have));
            chk("rsp_data",  32'(rsp_data),  32'(m_data));
            chk("rsp_kind",  32'(rsp_kind),  32'(m_kind));
            chk("rsp_pc",    32'(rsp_pc),    32'(m_rpc));
            chk("pc",        32'(pc),        32'(m_pc));
            if (rsp_valid) nvalid++;
            if (rsp_valid && rsp_ready && !pc_load) begin
                lg_pc.push_back(rsp_pc); lg_kind.push_back(rsp_kind); lg_data.push_back(rsp_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [2:0] k);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_kind  = k;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
            step();
        end
        step();
        req_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL req_accept timeout t=%0t", $time);
        end
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL rsp_wait timeout t=%0t", $time);
        end
    endtask

    logic [15:0] e_pc[3]   = '{16'h0100, 16'h0101, 16'h0102};
    logic [2:0]  e_kind[3] = '{3'd0, 3'd3, 3'd4};
    logic [7:0]  e_data[3] = '{8'hC3, 8'h50, 8'h01};

    initial begin
        // Reset
        step();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pc", 32'(pc), 32'h0100);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h00);
        chk("reset_rsp_kind", 32'(rsp_kind), 32'd0);
        chk("reset_rsp_pc", 32'(rsp_pc), 32'h0000);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0000);
        chk("reset_req_ready_rel", 32'(req_ready), 32'd1);
        step();

        // Sequential fetch, 1-cycle memory
        rsp_ready = 1'b1; lat = 0;
        dq.push_back(8'hC3); dq.push_back(8'h50); dq.push_back(8'h01);
        lg_pc.delete(); lg_kind.delete(); lg_data.delete();
        do_req(3'd0); do_req(3'd3); do_req(3'd4);
        repeat (4) step();
        @(negedge clk);
        chk("seq_count", 32'(lg_pc.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < lg_pc.size()) begin
                chk("seq_rsp_pc", 32'(lg_pc[i]), 32'(e_pc[i]));
                chk("seq_rsp_kind", 32'(lg_kind[i]), 32'(e_kind[i]));
                chk("seq_rsp_data", 32'(lg_data[i]), 32'(e_data[i]));
            end
        end
        chk("seq_final_pc", 32'(pc), 32'h0103);
        step();

        // Wait states and backpressure
        lat = 4; rsp_ready = 1'b0;
        do_req(3'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ws_mem_rd", 32'(mem_rd), 32'd1);
            chk("ws_mem_addr", 32'(mem_addr), 32'h0103);
            chk("ws_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        wait_rsp();
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h58);
            chk("bp_rsp_pc", 32'(rsp_pc), 32'h0103);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        step();
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_exit_valid", 32'(rsp_valid), 32'd0);
        chk("bp_exit_ready", 32'(req_ready), 32'd1);
        chk("bp_exit_pc", 32'(pc), 32'h0104);
        step();

        // Wrap-around
        lat = 0;
        pc_load = 1'b1; pc_load_value = 16'hFFFF;
        step();
        pc_load = 1'b0;
        @(negedge clk);
        chk("wrap_load", 32'(pc), 32'hFFFF);
        step();
        do_req(3'd6);
        wait_rsp();
        chk("wrap_rsp_pc", 32'(rsp_pc), 32'hFFFF);
        chk("wrap_rsp_kind", 32'(rsp_kind), 32'd6);
        step(); step();
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'h0000);
        step();

        // Jump during FETCH
        nvalid = 0; lat = 2;
        do_req(3'd0);
        step();
        pc_load = 1'b1; pc_load_value = 16'h0038;
        step();
        pc_load = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("jmp_no_rsp", 32'(nvalid), 32'd0);
        chk("jmp_pc", 32'(pc), 32'h0038);
        chk("jmp_idle", 32'(req_ready), 32'd1);
        step();
        lat = 0;
        do_req(3'd1);
        @(negedge clk);
        chk("jmp_next_addr", 32'(mem_addr), 32'h0038);
        wait_rsp();
        chk("jmp_next_rsp_pc", 32'(rsp_pc), 32'h0038);
        chk("jmp_next_data", 32'(rsp_data), 32'h62);
        step(); step();

        // pc_load + req_valid in IDLE
        pc_load = 1'b1; pc_load_value = 16'h0200; req_valid = 1'b1; req_kind = 3'd1;
        @(negedge clk);
        chk("sim_idle_ready", 32'(req_ready), 32'd0);
        step();
        pc_load = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("sim_idle_mem_rd", 32'(mem_rd), 32'd0);
        chk("sim_idle_pc", 32'(pc), 32'h0200);
        step();

        // pc_load + mem_rdata_valid in FETCH
        nvalid = 0;
        do_req(3'd5);
        pc_load = 1'b1; pc_load_value = 16'h0300;
        step();
        pc_load = 1'b0;
        @(negedge clk);
        chk("sim_fetch_valid", 32'(rsp_valid), 32'd0);
        chk("sim_fetch_pc", 32'(pc), 32'h0300);
        step(); step();
        @(negedge clk);
        chk("sim_fetch_nvalid", 32'(nvalid), 32'd0);
        chk("sim_fetch_ready", 32'(req_ready), 32'd1);
        step();

        // pc_load + rsp_ready in RESP
        lg_pc.delete(); lg_kind.delete(); lg_data.delete();
        rsp_ready = 1'b0;
        do_req(3'd7);
        step();
        pc_load = 1'b1; pc_load_value = 16'h0400; rsp_ready = 1'b1;
        @(negedge clk);
        chk("sim_resp_before", 32'(rsp_valid), 32'd1);
        step();
        pc_load = 1'b0;
        @(negedge clk);
        chk("sim_resp_valid", 32'(rsp_valid), 32'd0);
        chk("sim_resp_pc", 32'(pc), 32'h0400);
        chk("sim_resp_logged", 32'(lg_pc.size()), 32'd0);
        step();

        // Randomized run
        stray_en = 1;
        for (int c = 0; c < 3000; c++) begin
            req_valid     = ($urandom_range(3) != 0);
            req_kind      = 3'($urandom);
            rsp_ready     = ($urandom_range(3) != 0);
            lat           = $urandom_range(3);
            pc_load       = !m_orphan && ($urandom_range(15) == 0);
            pc_load_value = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            rst_n         = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1; req_valid = 1'b0; pc_load = 1'b0; stray_en = 0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
